// File: rtl/ibex_decode_queue.sv
// Decode queue: circular instruction buffer with class decode and a one/two-cycle issue FSM; 1-cycle latency, ready=!full.
// Optional same-cycle bypass into an empty queue when IBEX_DECODE_QUEUE_BYPASS_EN is defined.
module ibex_decode_queue #(
  parameter int unsigned DEPTH           = 4,
  parameter bit          RV32E           = 1'b0,
  parameter bit          BranchTargetALU = 1'b0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     instr_valid_i,
  output logic                     instr_ready_o,
  input  logic [31:0]              instr_rdata_i,
  input  logic [31:0]              instr_pc_i,
  input  logic                     illegal_c_insn_i,
  input  logic                     flush_i,
  input  logic                     ex_ready_i,
  input  logic                     branch_taken_i,
  output logic                     dec_valid_o,
  output logic [31:0]              dec_instr_o,
  output logic [31:0]              dec_pc_o,
  output logic [2:0]               dec_class_o,
  output logic                     dec_second_o,
  output logic [4:0]               rf_raddr_a_o,
  output logic [4:0]               rf_raddr_b_o,
  output logic [4:0]               rf_waddr_o,
  output logic                     rf_we_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] PTR_ZERO = '0;

  localparam logic [2:0] C_ALU     = 3'd0;
  localparam logic [2:0] C_LOAD    = 3'd1;
  localparam logic [2:0] C_STORE   = 3'd2;
  localparam logic [2:0] C_BRANCH  = 3'd3;
  localparam logic [2:0] C_JUMP    = 3'd4;
  localparam logic [2:0] C_SYSTEM  = 3'd5;
  localparam logic [2:0] C_MULDIV  = 3'd6;
  localparam logic [2:0] C_ILLEGAL = 3'd7;

  typedef enum logic [1:0] {
    S_EMPTY  = 2'd0,
    S_ISSUE  = 2'd1,
    S_SECOND = 2'd2
  } state_e;

  state_e      state_q;
  logic [AW:0] wptr_q, rptr_q, wptr_d, rptr_d;

  logic [31:0] instr_q [DEPTH];
  logic [31:0] pc_q    [DEPTH];
  logic        illc_q  [DEPTH];

  logic        full, empty, push_req, bypass_act;
  logic        head_vld, head_illc, issue_phase, two_cycle;
  logic        pop, to_second, do_pop, do_push;
  logic [31:0] head_instr, head_pc;

  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2, rd;
  logic [2:0]  cls;
  logic        use_rd, use_rs1, use_rs2, writes_rf;

  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty = (wptr_q == rptr_q);

  assign instr_ready_o = !full;
  assign count_o       = wptr_q - rptr_q;

  always_comb begin
    push_req = instr_valid_i && !full && !flush_i;
`ifdef IBEX_DECODE_QUEUE_BYPASS_EN
    bypass_act = empty && push_req;
`else
    bypass_act = 1'b0;
`endif
    head_vld   = (state_q != S_EMPTY) || bypass_act;
    head_instr = bypass_act ? instr_rdata_i    : instr_q[rptr_q[AW-1:0]];
    head_pc    = bypass_act ? instr_pc_i       : pc_q[rptr_q[AW-1:0]];
    head_illc  = bypass_act ? illegal_c_insn_i : illc_q[rptr_q[AW-1:0]];
  end

  assign opcode = head_instr[6:0];
  assign rd     = head_instr[11:7];
  assign funct3 = head_instr[14:12];
  assign rs1    = head_instr[19:15];
  assign rs2    = head_instr[24:20];
  assign funct7 = head_instr[31:25];

  // Register-field usage per class feeds the RV32E upper-register check.
  always_comb begin
    cls     = C_ILLEGAL;
    use_rd  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (opcode)
      7'h37, 7'h17: begin cls = C_ALU; use_rd = 1'b1; end
      7'h13: begin cls = C_ALU; use_rd = 1'b1; use_rs1 = 1'b1; end
      7'h33: begin
        cls     = (funct7 == 7'h01) ? C_MULDIV : C_ALU;
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      7'h03: begin cls = C_LOAD;   use_rd  = 1'b1; use_rs1 = 1'b1; end
      7'h23: begin cls = C_STORE;  use_rs1 = 1'b1; use_rs2 = 1'b1; end
      7'h63: begin cls = C_BRANCH; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      7'h6F: begin cls = C_JUMP;   use_rd  = 1'b1; end
      7'h67: begin cls = C_JUMP;   use_rd  = 1'b1; use_rs1 = 1'b1; end
      7'h73: begin
        cls     = C_SYSTEM;
        use_rd  = (funct3 != 3'd0);
        use_rs1 = (funct3[1:0] != 2'd0) && !funct3[2];
      end
      7'h0F:   cls = C_SYSTEM;
      default: cls = C_ILLEGAL;
    endcase
    if (head_illc) cls = C_ILLEGAL;
    if (RV32E && ((use_rd && rd[4]) || (use_rs1 && rs1[4]) || (use_rs2 && rs2[4])))
      cls = C_ILLEGAL;
  end

  always_comb begin
    writes_rf = 1'b0;
    case (cls)
      C_ALU, C_LOAD, C_JUMP, C_MULDIV: writes_rf = 1'b1;
      C_SYSTEM: writes_rf = (opcode == 7'h73) && (funct3 != 3'd0);
      default:  writes_rf = 1'b0;
    endcase
  end

  // A bypassed instruction is in its first issue cycle; if consumed single-cycle it never enters storage.
  always_comb begin
    issue_phase = (state_q == S_ISSUE) || bypass_act;
    two_cycle   = !BranchTargetALU && head_vld &&
                  ((cls == C_JUMP) || ((cls == C_BRANCH) && branch_taken_i));
    pop         = ex_ready_i && ((issue_phase && !two_cycle) || (state_q == S_SECOND));
    to_second   = issue_phase && ex_ready_i && two_cycle;
    do_pop      = pop && !bypass_act && !flush_i;
    do_push     = push_req && !(bypass_act && pop);
    wptr_d      = flush_i ? PTR_ZERO : (do_push ? wptr_q + PTR_ONE : wptr_q);
    rptr_d      = flush_i ? PTR_ZERO : (do_pop  ? rptr_q + PTR_ONE : rptr_q);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_EMPTY;
      wptr_q  <= PTR_ZERO;
      rptr_q  <= PTR_ZERO;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      if (flush_i)                          state_q <= S_EMPTY;
      else if (to_second)                   state_q <= S_SECOND;
      else if (wptr_d == rptr_d)            state_q <= S_EMPTY;
      else if (state_q == S_SECOND && !pop) state_q <= S_SECOND;
      else                                  state_q <= S_ISSUE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      instr_q[wptr_q[AW-1:0]] <= instr_rdata_i;
      pc_q[wptr_q[AW-1:0]]    <= instr_pc_i;
      illc_q[wptr_q[AW-1:0]]  <= illegal_c_insn_i;
    end
  end

  always_comb begin
    dec_valid_o  = head_vld;
    dec_instr_o  = '0;
    dec_pc_o     = '0;
    dec_class_o  = '0;
    dec_second_o = 1'b0;
    rf_raddr_a_o = '0;
    rf_raddr_b_o = '0;
    rf_waddr_o   = '0;
    rf_we_o      = 1'b0;
    if (head_vld) begin
      dec_instr_o  = head_instr;
      dec_pc_o     = head_pc;
      dec_class_o  = cls;
      dec_second_o = (state_q == S_SECOND);
      rf_raddr_a_o = rs1;
      rf_raddr_b_o = rs2;
      rf_waddr_o   = rd;
      rf_we_o      = writes_rf && (state_q != S_SECOND);
    end
  end

endmodule
